// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and types for the 5x5 convolution window producer.
package conv_pkg;
    localparam int BITWIDTH = 16;
    localparam int KSIZE = 5;
    typedef logic signed [BITWIDTH-1:0] pixel_t;
    typedef pixel_t [KSIZE-1:0][KSIZE-1:0] window_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel-in and window-out valid/ready streams of conv_window_gen.
interface conv_window_gen_if #(parameter int BITWIDTH = 16, parameter int IMG_W = 32, parameter int IMG_H = 32);
    import conv_pkg::*;
    logic in_valid;
    logic in_ready;
    logic signed [BITWIDTH-1:0] in_pixel;
    logic out_valid;
    logic out_ready;
    logic [KSIZE-1:0][KSIZE-1:0][BITWIDTH-1:0] map_block;
    logic [$clog2(IMG_H)-1:0] out_row;
    logic [$clog2(IMG_W)-1:0] out_col;
    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, map_block, out_row, out_col
    );
    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, map_block, out_row, out_col
    );
endinterface

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one image row of storage; a write returns the old value at that address.
module conv_line_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
    end
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a row-major pixel stream into 5x5 windows for the convolution point.
// Define STRIDE2_EN to emit only windows whose output row and column are both even.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int BITWIDTH = 16,
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    conv_window_gen_if.slave   bus,
    output logic               busy,
    output logic               done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
`ifdef STRIDE2_EN
    localparam logic STRIDE2 = 1'b1;
`else
    localparam logic STRIDE2 = 1'b0;
`endif

    typedef logic [BITWIDTH-1:0] pix_t;

    state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d, out_col_q, out_col_d;
    logic [RW-1:0] row_q, row_d, out_row_q, out_row_d;
    logic out_valid_q, out_valid_d;
    pix_t [KSIZE-1:0][KSIZE-1:0] win_q, win_d;
    pix_t new_col [KSIZE];
    logic acc, emit;

    assign bus.in_ready = state_q == RUN && (!out_valid_q || bus.out_ready);
    assign acc = bus.in_valid && bus.in_ready;
    assign emit = acc && row_q >= RW'(4) && col_q >= CW'(4) && (!STRIDE2 || (!row_q[0] && !col_q[0]));
    assign busy = state_q != IDLE;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row = out_row_q;
    assign bus.out_col = out_col_q;
    assign bus.map_block = out_valid_q ? win_q : '0;

    // Buffer k holds row r-4+k; on write it hands its old pixel down to buffer k-1.
    for (genvar k = 0; k < KSIZE - 1; k++) begin : g_lb
        conv_line_buffer #(.WIDTH(BITWIDTH), .DEPTH(IMG_W)) u_lb (
            .clk   (clk),
            .we    (acc),
            .addr  (col_q),
            .wdata (new_col[k+1]),
            .rdata (new_col[k])
        );
    end
    assign new_col[KSIZE-1] = bus.in_pixel;

    always_comb begin
        state_d = state_q;
        col_d = col_q;
        row_d = row_q;
        win_d = win_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        out_valid_d = emit || (out_valid_q && !bus.out_ready);
        done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    col_d = '0;
                    row_d = '0;
                end
            end
            RUN: begin
                if (acc) begin
                    col_d = col_q == COL_LAST ? '0 : col_q + 1'b1;
                    row_d = col_q == COL_LAST ? row_q + 1'b1 : row_q;
                    state_d = (row_q == ROW_LAST && col_q == COL_LAST) ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                // Under stride 2 the final pixel may produce no window, so an empty output also finishes.
                if (!out_valid_q || bus.out_ready) begin
                    done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (acc) begin
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE - 1; j++) win_d[i][j] = win_q[i][j+1];
                win_d[i][KSIZE-1] = new_col[i];
            end
        end
        if (emit) begin
            out_row_d = row_q - RW'(4);
            out_col_d = col_q - CW'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q <= '0;
            row_q <= '0;
            out_row_q <= '0;
            out_col_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q <= col_d;
            row_q <= row_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        win_q <= win_d;
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: 8x8 frames of pixel r*8+c; expected windows queued on input, checked on output.
module tb_conv_window_gen;
    import conv_pkg::*;
    localparam int W = 8;
    localparam int H = 8;
    localparam int BW = 16;
`ifdef STRIDE2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int NWIN = ((H - 4 + STEP - 1) / STEP) * ((W - 4 + STEP - 1) / STEP);
    localparam int LASTC = ((W - 5) / STEP) * STEP;
    localparam int LAST44 = (LASTC + 4) * W + ((H - 5) / STEP) * STEP + 4;

    typedef logic [KSIZE-1:0][KSIZE-1:0][BW-1:0] blk_t;
    typedef struct {
        int   row;
        int   col;
        blk_t blk;
    } exp_t;

    exp_t q[$];
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic busy, done;
    int checks = 0, fails = 0;
    int win_cnt = 0, done_cnt = 0, ready_mode = 0, cyc = 0;
    int prow = -1, pcol = -1;

    conv_window_gen_if #(.BITWIDTH(BW), .IMG_W(W), .IMG_H(H)) bus();

    conv_window_gen #(.BITWIDTH(BW), .IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic blk_t mk(input int r, input int c);
        blk_t b;
        for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++) b[i][j] = BW'((r + i) * W + c + j);
        return b;
    endfunction

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.out_ready = (ready_mode == 0) || (cyc % 3 != 0);
        end
    end

    // Monitor: pops the scoreboard on every accepted window and watches stall behaviour.
    initial begin
        exp_t e;
        blk_t held;
        int hrow, hcol;
        logic hold = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) hold = 1'b0;
            if (hold) begin
                check("stall_valid", bus.out_valid, 1);
                checks++;
                if (bus.map_block !== held) begin
                    fails++;
                    $display("FAIL stall_block: got %h expected %h", bus.map_block, held);
                end
                check("stall_row", bus.out_row, hrow);
                check("stall_col", bus.out_col, hcol);
            end
            hold = bus.out_valid && !bus.out_ready;
            if (hold) begin
                held = bus.map_block;
                hrow = bus.out_row;
                hcol = bus.out_col;
                check("stall_in_ready", bus.in_ready, 0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_window: got row %0d col %0d expected none", bus.out_row, bus.out_col);
                end else begin
                    e = q.pop_front();
                    check("win_row", bus.out_row, e.row);
                    check("win_col", bus.out_col, e.col);
                    checks++;
                    if (bus.map_block !== e.blk) begin
                        fails++;
                        $display("FAIL win_block: got %h expected %h", bus.map_block, e.blk);
                    end
                    if (win_cnt == 0) begin
                        check("first_00", bus.map_block[0][0], 0);
                        check("first_04", bus.map_block[0][4], 4);
                        check("first_40", bus.map_block[4][0], 32);
                        check("first_44", bus.map_block[4][4], 36);
                    end
                    if (win_cnt == NWIN - 1) check("last_44", bus.map_block[4][4], LAST44);
                    if (prow >= 0 && pcol == LASTC) begin
                        check("rowwrap_row", bus.out_row, prow + STEP);
                        check("rowwrap_col", bus.out_col, 0);
                        check("rowwrap_44", bus.map_block[4][4], (prow + STEP + 4) * W + 4);
                    end
`ifdef STRIDE2_EN
                    if (e.row == 2 && e.col == 2) check("s2_22_00", bus.map_block[0][0], 18);
`endif
                    prow = bus.out_row;
                    pcol = bus.out_col;
                    win_cnt++;
                end
            end
            if (done) begin
                done_cnt++;
                check("done_queue_empty", q.size(), 0);
            end
        end
    end

    task automatic run_frame(input int mode, input int rst_at, input int start_at);
        logic rdy;
        int last_gap = -1;
        exp_t e;
        win_cnt = 0;
        done_cnt = 0;
        prow = -1;
        pcol = -1;
        ready_mode = mode;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        for (int p = 0; p < W * H;) begin
            if (p == rst_at) begin
                bus.in_valid = 1'b0;
                rst_n = 1'b0;
                q.delete();
                prow = -1;
                @(negedge clk);
                check("rst_out_valid", bus.out_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_in_ready", bus.in_ready, 0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    check("post_rst_no_output", bus.out_valid, 0);
                end
                @(posedge clk);
                #1;
                return;
            end
            if (p % 13 == 7 && last_gap != p) begin
                last_gap = p;
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_pixel = BW'(p);
            if (p == start_at) start = 1'b1;
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (rdy) begin
                if (p / W >= 4 && p % W >= 4 && (p / W - 4) % STEP == 0 && (p % W - 4) % STEP == 0) begin
                    e.row = p / W - 4;
                    e.col = p % W - 4;
                    e.blk = mk(e.row, e.col);
                    q.push_back(e);
                end
                p++;
            end
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 200 && done_cnt == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("done_once", done_cnt, 1);
        check("win_count", win_cnt, NWIN);
        check("queue_drained", q.size(), 0);
        check("idle_busy", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_out_row", bus.out_row, 0);
        check("reset_out_col", bus.out_col, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(0, -1, 20);
        run_frame(1, -1, -1);
        run_frame(0, 40, -1);
        run_frame(0, -1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Streaming producer for the 5x5 convolution datapath.
- Accepts a row-major pixel stream of one IMG_H x IMG_W feature map.
- Buffers four previous rows internally.
- Emits every valid-position 5x5 window as a map_block array, indexed exactly as the convolution point consumes it.
- Sits between the feature-map memory reader and the convolution point, with valid/ready handshakes on both sides.

Parameters:
- BITWIDTH, 16, pixel width (signed), same as the convolution datapath.
- IMG_W, 32, image width in pixels; must be >= 5.
- IMG_H, 32, image height in pixels; must be >= 5.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: begin a frame; ignored unless state is IDLE.
- in_valid  input  1  in_pixel is valid.
- in_ready  output  1  block accepts in_pixel this cycle.
- in_pixel  input  BITWIDTH  signed pixel, row-major order.
- out_valid  output  1  map_block, out_row and out_col are valid.
- out_ready  input  1  consumer accepts the window this cycle.
- map_block  output  [BITWIDTH-1:0] x [4:0][4:0]  signed window; [0][0] is top-left (oldest row, oldest column), [4][4] is the newest pixel.
- out_row  output  $clog2(IMG_H)  output-map row of the window (0..IMG_H-5).
- out_col  output  $clog2(IMG_W)  output-map column of the window (0..IMG_W-5).
- busy  output  1  high while in RUN or DRAIN.
- done  output  1  one-cycle pulse when the last window of the frame is accepted.

Behaviour:
Reset values:
- All outputs 0.
- Line buffers and window registers are not reset; contents are don't-care.
- Counters are 0 and the state is IDLE.

States:
- IDLE: in_ready=0. On start, clear counters and go to RUN.
- RUN:
  - in_ready = !out_valid || out_ready.
  - On each in_valid&&in_ready, shift the pixel in and advance the input col/row counters; col wraps at IMG_W-1, after which row increments.
  - When the last pixel (row IMG_H-1, col IMG_W-1) is accepted, go to DRAIN.
- DRAIN:
  - in_ready=0.
  - Wait until the final window is accepted (out_valid&&out_ready).
  - Then pulse done for one cycle and go to IDLE.

Window formation:
- A 5x5 register array shifts left by one column per accepted pixel.
- The new rightmost column is filled from line buffers 0..3 (rows r-4..r-1) plus in_pixel (row r).
- Line buffer k writes the value it outputs into line buffer k-1's position (cascade). Each buffer has depth IMG_W, addressed by the input column.

Output registration:
- The window is registered and out_valid set one cycle after accepting a pixel at input row>=4 and col>=4.
- out_row = row-4 and out_col = col-4 are registered alongside it.
- No window is emitted for col<4; horizontal wrap-around windows are never produced.
- Total windows per frame = (IMG_H-4)*(IMG_W-4).

Handshake:
- map_block, out_row and out_col are held stable while out_valid && !out_ready.
- out_valid drops after acceptance unless a new window is produced in the same cycle.
- Pixel acceptance and window acceptance in the same cycle are legal; the new window replaces the old one.

Boundary conditions:
- start while busy is ignored.
- rst_n asserted mid-frame: return to IDLE immediately with out_valid=0; the partial frame is discarded.
- in_valid with in_ready=0 does not consume the pixel.

Width rules:
- No arithmetic on pixel data; the block is pass-through only.

Optional Feature:
STRIDE2_EN.
- Defined: a window is emitted only when both out_row and out_col are even; output count is ceil((IMG_H-4)/2)*ceil((IMG_W-4)/2). Skipped positions do not assert out_valid and do not stall input. out_row and out_col still report full-resolution positions.
- Undefined: stride 1, every valid position is emitted.

Decomposition:
- Package conv_pkg: KSIZE=5 constant, pixel_t (signed BITWIDTH), window_t (pixel_t [KSIZE-1:0][KSIZE-1:0]), state enum {IDLE, RUN, DRAIN}.
- Sub-module conv_line_buffer: single-port-read/write RAM of depth IMG_W that returns the old value at the written address; four instances.

Test Plan:
- IMG_W=IMG_H=8, pixel = r*8+c, out_ready=1 → 16 windows. First window: out_row=0, out_col=0, map_block[0][0]=0, [0][4]=4, [4][0]=32, [4][4]=36. Last window: [4][4]=63. done pulses once after it.
- Same frame with out_ready toggling 1-in-3 → map_block stable during stalls, in_ready low whenever out_valid&&!out_ready, identical window sequence.
- Row boundary: window at out_col=3 is followed directly by out_row+1, out_col=0, with [4][4]=r*8+4 of the next row. No wrap windows occur.
- rst_n low at pixel 40 of a frame, then a fresh start → first window again has [0][0]=0, with no stale output between.
- start pulsed during RUN → ignored; window count stays 16.
- STRIDE2_EN defined, 8x8 frame → exactly 4 windows at (0,0),(0,2),(2,0),(2,2); the (2,2) window has [0][0]=18.
